// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: passes UART commands through when idle and splits each move into two legs during a tour.
// Build option TOUR_FANFARE_EN: leg2 uses opcode 0011 so the fanfare plays on each landing; otherwise leg2 uses 0010.
module tour_cmd #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp
);

  typedef enum logic [2:0] {IDLE, LEG1, WAIT1, LEG2, WAIT2} state_t;

  localparam logic [3:0] OP_LEG1 = 4'b0010;
`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] OP_LEG2 = 4'b0011;
`else
  localparam logic [3:0] OP_LEG2 = 4'b0010;
`endif

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_STEP = 8'h5A;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_mv_indx;
  logic [IDX_W-1:0] w_mv_indx_nxt;
  logic [15:0]      w_leg1_cmd;
  logic [15:0]      w_leg2_cmd;
  logic             w_move_none;

  // Lowest set bit selects the move; leg1 is the two-square run, leg2 the one-square hook.
  function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input logic second);
    logic [7:0] h1;
    logic [7:0] h2;
    h1 = HDG_N;
    h2 = HDG_W;
    casez (mv)
      8'b???????1: begin h1 = HDG_N; h2 = HDG_W; end
      8'b??????10: begin h1 = HDG_N; h2 = HDG_E; end
      8'b?????100: begin h1 = HDG_W; h2 = HDG_N; end
      8'b????1000: begin h1 = HDG_W; h2 = HDG_S; end
      8'b???10000: begin h1 = HDG_S; h2 = HDG_W; end
      8'b??100000: begin h1 = HDG_S; h2 = HDG_E; end
      8'b?1000000: begin h1 = HDG_E; h2 = HDG_S; end
      8'b10000000: begin h1 = HDG_E; h2 = HDG_N; end
      default:     begin h1 = HDG_N; h2 = HDG_W; end
    endcase
    if (second) leg_cmd = {OP_LEG2, h2, 4'd1};
    else        leg_cmd = {OP_LEG1, h1, 4'd2};
  endfunction

  assign w_leg1_cmd  = leg_cmd(move, 1'b0);
  assign w_leg2_cmd  = leg_cmd(move, 1'b1);
  assign w_move_none = (move == 8'h00);
  assign mv_indx     = r_mv_indx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mv_indx <= w_mv_indx_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mv_indx_nxt    = r_mv_indx;
    cmd              = w_leg1_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_DONE;
    case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        if (start_tour) begin
          w_mv_indx_nxt = '0;
          w_state_nxt   = LEG1;
        end
      end
      LEG1: begin
        // An empty move entry ends the tour early without issuing anything.
        if (w_move_none) begin
          w_state_nxt = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) w_state_nxt = WAIT1;
        end
      end
      WAIT1: begin
        if (send_resp) begin
          resp        = RESP_STEP;
          w_state_nxt = LEG2;
        end
      end
      LEG2: begin
        cmd = w_leg2_cmd;
        if (w_move_none) begin
          w_state_nxt = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) w_state_nxt = WAIT2;
        end
      end
      WAIT2: begin
        cmd = w_leg2_cmd;
        if (send_resp) begin
          if (r_mv_indx == LAST_IDX) begin
            resp          = RESP_DONE;
            w_mv_indx_nxt = '0;
            w_state_nxt   = IDLE;
          end else begin
            resp          = RESP_STEP;
            w_mv_indx_nxt = r_mv_indx + IDX_W'(1);
            w_state_nxt   = LEG1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: stimulus queues expected command/response words, a negedge monitor pops and compares.
module tb_tour_cmd;
  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] OP2 = 4'h3;
`else
  localparam logic [3:0] OP2 = 4'h2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_tour = 1'b0;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd_UART = 16'h0000;
  logic             cmd_rdy_UART = 1'b0;
  logic             clr_cmd_rdy_UART;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy = 1'b0;
  logic             send_resp = 1'b0;
  logic [7:0]       resp;

  logic [7:0] mem [32];
  assign move = mem[mv_indx];

  tour_cmd #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
  );

  always #5 clk = ~clk;

  // Hand-decoded legs per move bit (leg2 keeps heading/squares; opcode added per build).
  logic [15:0] L1 [8] = '{16'h2002, 16'h2002, 16'h23F2, 16'h23F2, 16'h27F2, 16'h27F2, 16'h2BF2, 16'h2BF2};
  logic [11:0] L2 [8] = '{12'h3F1, 12'hBF1, 12'h001, 12'h7F1, 12'h3F1, 12'hBF1, 12'h7F1, 12'h001};

  typedef struct packed { logic is_resp; logic [15:0] val; } exp_t;
  exp_t sb [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop(input logic is_resp, input logic [15:0] act, input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %h with no expected entry", nm, act);
    end else begin
      e = sb.pop_front();
      chk({nm, "_kind"}, 32'(is_resp), 32'(e.is_resp));
      chk(nm, 32'(act), 32'(e.val));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmd_rdy && clr_cmd_rdy) pop(1'b0, cmd, "sb_cmd");
    if (rst_n && send_resp)              pop(1'b1, {8'h00, resp}, "sb_resp");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowbit(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic leg(input string nm, input logic [15:0] exp_cmd, input logic [7:0] exp_resp,
                     input bit do_resp, input bit poke_start);
    int w;
    w = 0;
    while (!cmd_rdy && w < 20) begin
      step();
      w++;
    end
    chk({nm, "_latency"}, 32'(w), 32'd0);
    if (!cmd_rdy) return;
    sb.push_back(exp_t'({1'b0, exp_cmd}));
    clr_cmd_rdy = 1'b1;
    #1;
    chk({nm, "_uart_held"}, 32'(clr_cmd_rdy_UART), 32'd0);
    step();
    clr_cmd_rdy = 1'b0;
    #1;
    chk({nm, "_wait_rdy"}, 32'(cmd_rdy), 32'd0);
    chk({nm, "_wait_cmd"}, 32'(cmd), 32'(exp_cmd));
    if (poke_start) start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    step();
    if (do_resp) begin
      sb.push_back(exp_t'({1'b1, 8'h00, exp_resp}));
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;
    end
  endtask

  task automatic move_full(input int idx, input bit last, input bit poke_start);
    int b;
    b = lowbit(mem[idx]);
    chk("mv_indx", 32'(mv_indx), 32'(idx));
    leg("leg1", L1[b], 8'h5A, 1'b1, poke_start);
    leg("leg2", {OP2, L2[b]}, last ? 8'hA5 : 8'h5A, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    // Reset state
    step();
    step();
    chk("rst_mv_indx", 32'(mv_indx), 32'd0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_resp", 32'(resp), 32'hA5);
    rst_n = 1'b1;
    step();

    // UART pass-through
    cmd_UART = 16'h2003;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("uart_cmd", 32'(cmd), 32'h2003);
    chk("uart_rdy", 32'(cmd_rdy), 32'd1);
    sb.push_back(exp_t'({1'b0, 16'h2003}));
    clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_clr", 32'(clr_cmd_rdy_UART), 32'd1);
    step();
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;
    #1;
    chk("uart_clr_low", 32'(clr_cmd_rdy_UART), 32'd0);
    sb.push_back(exp_t'({1'b1, 16'h00A5}));
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;

    // Short tour: decode patterns, held UART request, ignored restart, early stop at index 5
    mem[0] = 8'h01; mem[1] = 8'h40; mem[2] = 8'h02; mem[3] = 8'hF8; mem[4] = 8'h80; mem[5] = 8'h00;
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    move_full(0, 1'b0, 1'b0);
    move_full(1, 1'b0, 1'b0);
    move_full(2, 1'b0, 1'b1);
    move_full(3, 1'b0, 1'b0);
    move_full(4, 1'b0, 1'b0);
    chk("term_mv_indx", 32'(mv_indx), 32'd5);
    chk("term_no_rdy", 32'(cmd_rdy), 32'd0);
    step();
    chk("term_idle_rdy", 32'(cmd_rdy), 32'd1);
    chk("term_idle_cmd", 32'(cmd), 32'h1234);
    sb.push_back(exp_t'({1'b0, 16'h1234}));
    clr_cmd_rdy = 1'b1;
    #1;
    chk("held_uart_clr", 32'(clr_cmd_rdy_UART), 32'd1);
    step();
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;

    // Full 24-move tour
    for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'(1 << (i % 8));
    mem[3]  = 8'hF8;
    mem[10] = 8'h60;
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) move_full(i, i == NUM_MOVES - 1, 1'b0);
    cmd_UART = 16'hABCD;
    #1;
    chk("tour_end_mv_indx", 32'(mv_indx), 32'd0);
    chk("tour_end_cmd", 32'(cmd), 32'hABCD);
    chk("tour_end_rdy", 32'(cmd_rdy), 32'd0);
    chk("tour_end_resp", 32'(resp), 32'hA5);

    // Reset while in WAIT2 of move 7
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    for (int i = 0; i < 7; i++) move_full(i, 1'b0, 1'b0);
    chk("mid_mv_indx", 32'(mv_indx), 32'd7);
    leg("mid_leg1", L1[lowbit(mem[7])], 8'h5A, 1'b1, 1'b0);
    leg("mid_leg2", {OP2, L2[lowbit(mem[7])]}, 8'h5A, 1'b0, 1'b0);
    cmd_UART = 16'h2003;
    cmd_rdy_UART = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mv_indx", 32'(mv_indx), 32'd0);
    chk("mid_rst_rdy", 32'(cmd_rdy), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy", 32'(cmd_rdy), 32'd1);
    chk("post_rst_cmd", 32'(cmd), 32'h2003);
    chk("post_rst_mv_indx", 32'(mv_indx), 32'd0);
    chk("post_rst_clr", 32'(clr_cmd_rdy_UART), 32'd0);
    cmd_rdy_UART = 1'b0;
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
